// File: rtl/wb_fifo_drain.sv
`timescale 1ns/1ps
// Wishbone master that polls a byte FIFO peripheral, pops bytes onto a valid/ready
// stream, issues FIFO resets on request and aborts any bus cycle that is never acked.
module wb_fifo_drain #(
    parameter logic [31:0] BASE_ADR = 32'h0,
    parameter int unsigned POLL_DIV = 16,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        enable,
    input  logic        flush,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        busy,
    output logic        err
);

    localparam int unsigned PW = $clog2(POLL_DIV + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_DIV - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [31:0] ADR_STAT = BASE_ADR;
    localparam logic [31:0] ADR_DATA = BASE_ADR + 32'd4;
    localparam logic [31:0] ADR_RST  = BASE_ADR + 32'd12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_STAT,
        S_RD_DATA,
        S_OUT,
        S_WAIT,
        S_FLUSH
    } state_t;

    state_t          state;
    logic            cyc;
    logic [PW-1:0]   poll_cnt;
    logic [TW-1:0]   tmo_cnt;
    logic            flush_pend;
    logic            flush_rearm;
    logic            unused_dat_hi;

    // A single register drives both cyc and stb so they can never disagree.
    assign wbm_cyc_o     = cyc;
    assign wbm_stb_o     = cyc;
    assign wbm_dat_o     = 32'h0;
    assign unused_dat_hi = &{1'b0, wbm_dat_i[31:8]};

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: the async reset clears cyc at once, so a reset mid-cycle releases the bus without waiting for a clock.
        if (!reset_n) begin
            state       <= S_IDLE;
            cyc         <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_adr_o   <= 32'h0;
            wbm_sel_o   <= 4'h0;
            m_data      <= 8'h0;
            m_valid     <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
            poll_cnt    <= '0;
            tmo_cnt     <= '0;
            flush_pend  <= 1'b0;
            flush_rearm <= 1'b0;
        end else begin
            // A pulse seen while a flush is already running must trigger one more flush.
            if (flush) begin
                flush_pend <= 1'b1;
                if (state == S_FLUSH) flush_rearm <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (flush_pend) begin
                        state <= S_FLUSH;
                        busy  <= 1'b1;
                    end else if (enable) begin
                        state <= S_RD_STAT;
                        busy  <= 1'b1;
                    end
                end

                // Bus states enter with cyc low and start the cycle one clock later,
                // which guarantees an idle bus clock after every consumed ack.
                S_RD_STAT, S_RD_DATA, S_FLUSH: begin
                    if (!cyc) begin
                        cyc       <= 1'b1;
                        wbm_sel_o <= 4'hF;
                        tmo_cnt   <= '0;
                        wbm_we_o  <= (state == S_FLUSH);
                        if (state == S_RD_STAT)      wbm_adr_o <= ADR_STAT;
                        else if (state == S_RD_DATA) wbm_adr_o <= ADR_DATA;
                        else                         wbm_adr_o <= ADR_RST;
                    end else if (wbm_ack_i) begin
                        cyc       <= 1'b0;
                        wbm_sel_o <= 4'h0;
                        wbm_we_o  <= 1'b0;
                        if (state == S_RD_STAT) begin
                            if (wbm_dat_i[0]) begin
                                state    <= S_WAIT;
                                poll_cnt <= '0;
                                busy     <= 1'b0;
                            end else begin
                                state <= S_RD_DATA;
                            end
                        end else if (state == S_RD_DATA) begin
                            m_data  <= wbm_dat_i[7:0];
                            m_valid <= 1'b1;
                            state   <= S_OUT;
                        end else begin
                            flush_pend  <= flush_rearm | flush;
                            flush_rearm <= 1'b0;
                            err         <= 1'b0;
                            state       <= S_IDLE;
                            busy        <= 1'b0;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        // Abandoned cycle: a failed flush keeps flush_pend and retries after WAIT.
                        cyc         <= 1'b0;
                        wbm_sel_o   <= 4'h0;
                        wbm_we_o    <= 1'b0;
                        err         <= 1'b1;
                        flush_rearm <= 1'b0;
                        state       <= S_WAIT;
                        poll_cnt    <= '0;
                        busy        <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                S_OUT: begin
                    if (flush_pend) begin
                        m_valid <= 1'b0;
                        state   <= S_FLUSH;
                    end else if (m_ready) begin
                        m_valid <= 1'b0;
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end

                S_WAIT: begin
                    if (flush_pend || poll_cnt == POLL_LAST) begin
                        state    <= S_IDLE;
                        poll_cnt <= '0;
                    end else begin
                        poll_cnt <= poll_cnt + 1'b1;
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    cyc       <= 1'b0;
                    wbm_sel_o <= 4'h0;
                    wbm_we_o  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_fifo_drain.sv
`timescale 1ns/1ps
// Self-checking bench for wb_fifo_drain: behavioural FIFO slave, bus log and
// a byte scoreboard filled when bytes are loaded into the slave.
module tb_wb_fifo_drain;

    localparam int POLL_DIV = 4;
    localparam int TIMEOUT  = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_dat_i = 32'h0;
    logic        wbm_ack_i = 1'b0;
    logic        enable = 1'b0;
    logic        flush = 1'b0;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        busy, err;

    int n_tests = 0;
    int n_fail  = 0;

    // slave model state
    logic [7:0]  slv_q[$];
    bit          no_ack = 1'b0;
    int          ack_delay = 0;
    int          slv_wait = 0;
    int          cyc_len = 0;
    int          aborts = 0;
    int          abort_len = 0;
    int          cyc_n = 0;
    bit          log_we[$];
    logic [31:0] log_adr[$];
    int          log_t[$];

    // scoreboard
    logic [7:0]  exp_q[$];
    bit          mv_prev = 1'b0;
    int          valid_rises = 0;

    wb_fifo_drain #(.BASE_ADR(32'h0), .POLL_DIV(POLL_DIV), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_adr_o(wbm_adr_o), .wbm_sel_o(wbm_sel_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i),
        .enable(enable), .flush(flush),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Slave: acks on the falling edge, so the DUT samples ack on the next rising edge.
    always @(negedge clk) begin
        cyc_n++;
        if (!reset_n) begin
            wbm_ack_i = 1'b0;
            slv_wait  = 0;
            cyc_len   = 0;
        end else if (wbm_ack_i) begin
            wbm_ack_i = 1'b0;
            check("cyc_low_after_ack", {31'h0, wbm_cyc_o}, 32'h0);
            slv_wait = 0;
            cyc_len  = 0;
        end else if (wbm_cyc_o) begin
            cyc_len++;
            if (!no_ack && slv_wait >= ack_delay) begin
                check("stb_eq_cyc", {31'h0, wbm_stb_o}, 32'h1);
                check("sel_full", {28'h0, wbm_sel_o}, 32'hF);
                check("dat_o_zero", wbm_dat_o, 32'h0);
                wbm_ack_i = 1'b1;
                wbm_dat_i = 32'h0;
                if (wbm_we_o) begin
                    if (wbm_adr_o == 32'hC) slv_q.delete();
                end else if (wbm_adr_o == 32'h0) begin
                    wbm_dat_i = {31'h0, slv_q.size() == 0};
                end else if (wbm_adr_o == 32'h4 && slv_q.size() > 0) begin
                    wbm_dat_i = {24'h0, slv_q.pop_front()};
                end
                log_we.push_back(wbm_we_o);
                log_adr.push_back(wbm_adr_o);
                log_t.push_back(cyc_n);
            end else begin
                slv_wait++;
            end
        end else begin
            if (cyc_len > 0) begin
                aborts++;
                abort_len = cyc_len;
            end
            cyc_len  = 0;
            slv_wait = 0;
        end
    end

    // Scoreboard: each new byte presentation is compared against the next loaded byte.
    always @(negedge clk) begin
        if (!reset_n) begin
            mv_prev = 1'b0;
        end else begin
            if (m_valid && !mv_prev) begin
                valid_rises++;
                if (exp_q.size() == 0) check("sb_unexpected_valid", {31'h0, m_valid}, 32'h0);
                else check("sb_data", {24'h0, m_data}, {24'h0, exp_q.pop_front()});
            end
            mv_prev = m_valid;
        end
    end

    task automatic do_reset();
        reset_n   = 1'b0;
        enable    = 1'b0;
        flush     = 1'b0;
        m_ready   = 1'b0;
        no_ack    = 1'b0;
        ack_delay = 0;
        @(negedge clk);
        slv_q.delete();
        exp_q.delete();
        log_we.delete();
        log_adr.delete();
        log_t.delete();
        aborts = 0;
        valid_rises = 0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic load_byte(input logic [7:0] b);
        slv_q.push_back(b);
        exp_q.push_back(b);
    endtask

    task automatic wait_log(input int n, input int budget, input string tag);
        int b = budget;
        while (log_adr.size() < n && b > 0) begin
            @(negedge clk);
            b--;
        end
        check(tag, {31'h0, log_adr.size() >= n}, 32'h1);
    endtask

    task automatic wait_valid(input logic lvl, input int budget, input string tag);
        int b = budget;
        while (m_valid !== lvl && b > 0) begin
            @(negedge clk);
            b--;
        end
        check(tag, {31'h0, m_valid}, {31'h0, lvl});
    endtask

    task automatic pulse_flush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int nlog;
        int b;
        logic [31:0] exp_adr[5];

        // ---- reset state
        #12;
        check("rst_cyc", {31'h0, wbm_cyc_o}, 32'h0);
        check("rst_stb", {31'h0, wbm_stb_o}, 32'h0);
        check("rst_ctl", {wbm_we_o, wbm_sel_o, m_valid, busy, err}, 32'h0);
        check("rst_adr", wbm_adr_o, 32'h0);
        check("rst_mdata", {24'h0, m_data}, 32'h0);
        do_reset();
        repeat (10) @(negedge clk);
        check("idle_no_bus", log_adr.size(), 0);
        check("idle_not_busy", {31'h0, busy}, 32'h0);

        // ---- empty FIFO polling
        do_reset();
        enable = 1'b1;
        repeat (40) @(negedge clk);
        bad = 0;
        foreach (log_adr[i]) if (log_adr[i] != 32'h0 || log_we[i]) bad++;
        check("poll_only_status", bad, 0);
        check("poll_count_ge5", {31'h0, log_adr.size() >= 5}, 32'h1);
        if (log_t.size() >= 4)
            for (int i = 0; i < 3; i++) check("poll_interval", log_t[i+1] - log_t[i], 7);
        check("poll_no_valid", valid_rises, 0);

        // ---- two bytes, consumer always ready
        do_reset();
        load_byte(8'hA5);
        load_byte(8'h3C);
        m_ready = 1'b1;
        enable  = 1'b1;
        wait_log(5, 80, "two_bytes_log_len");
        exp_adr = '{32'h0, 32'h4, 32'h0, 32'h4, 32'h0};
        if (log_adr.size() >= 5)
            for (int i = 0; i < 5; i++) check("two_bytes_seq", {log_we[i], log_adr[i][30:0]}, exp_adr[i]);
        check("two_bytes_sb_empty", exp_q.size(), 0);
        check("two_bytes_rises", valid_rises, 2);

        // ---- back-pressure hold
        do_reset();
        load_byte(8'h77);
        enable = 1'b1;
        wait_valid(1'b1, 60, "hold_valid_up");
        nlog = log_adr.size();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!m_valid || m_data != 8'h77 || wbm_cyc_o || !busy) bad++;
        end
        check("hold_stable", bad, 0);
        check("hold_no_bus", log_adr.size(), nlog);
        m_ready = 1'b1;
        @(negedge clk);
        check("hold_release", {31'h0, m_valid}, 32'h0);

        // ---- flush while holding a byte
        do_reset();
        load_byte(8'h12);
        enable = 1'b1;
        wait_valid(1'b1, 60, "flush_valid_up");
        check("flush_held_data", {24'h0, m_data}, 32'h12);
        pulse_flush();
        wait_valid(1'b0, 3, "flush_valid_drop");
        wait_log(4, 60, "flush_log_len");
        if (log_adr.size() >= 4) begin
            check("flush_write", {log_we[2], log_adr[2][30:0]}, 32'h8000_000C);
            check("flush_then_poll", {log_we[3], log_adr[3][30:0]}, 32'h0);
        end
        check("flush_err_clear", {31'h0, err}, 32'h0);

        // ---- ack timeout, then an acked flush clears err
        do_reset();
        no_ack = 1'b1;
        enable = 1'b1;
        b = 60;
        while (aborts == 0 && b > 0) begin
            @(negedge clk);
            b--;
        end
        check("tmo_abort_seen", {31'h0, aborts > 0}, 32'h1);
        check("tmo_len", abort_len, TIMEOUT);
        check("tmo_err_set", {31'h0, err}, 32'h1);
        check("tmo_no_ack_log", log_adr.size(), 0);
        check("tmo_no_valid", {31'h0, m_valid}, 32'h0);
        enable = 1'b0;
        repeat (2 * TIMEOUT + POLL_DIV + 4) @(negedge clk);
        check("tmo_err_sticky", {31'h0, err}, 32'h1);
        check("tmo_idle", {31'h0, wbm_cyc_o}, 32'h0);
        no_ack = 1'b0;
        pulse_flush();
        wait_log(1, 40, "tmo_flush_acked");
        if (log_adr.size() >= 1) check("tmo_flush_adr", {log_we[0], log_adr[0][30:0]}, 32'h8000_000C);
        repeat (2) @(negedge clk);
        check("tmo_err_cleared", {31'h0, err}, 32'h0);

        // ---- asynchronous reset in the middle of a data read
        do_reset();
        ack_delay = 4;
        load_byte(8'h5A);
        m_ready = 1'b1;
        enable  = 1'b1;
        b = 80;
        while (!(wbm_cyc_o && wbm_adr_o == 32'h4) && b > 0) begin
            @(negedge clk);
            b--;
        end
        check("arst_in_rd_data", {31'h0, wbm_cyc_o && wbm_adr_o == 32'h4}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_cyc", {31'h0, wbm_cyc_o}, 32'h0);
        check("arst_stb", {31'h0, wbm_stb_o}, 32'h0);
        check("arst_valid", {31'h0, m_valid}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        b = 10;
        while (!wbm_cyc_o && b > 0) begin
            @(negedge clk);
            b--;
        end
        check("arst_first_cycle", {wbm_cyc_o, wbm_we_o, wbm_adr_o[29:0]}, 32'h8000_0000);
        b = 120;
        while (exp_q.size() != 0 && b > 0) begin
            @(negedge clk);
            b--;
        end
        check("arst_byte_delivered", exp_q.size(), 0);

        enable = 1'b0;
        repeat (20) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_fifo_drain.md
Name: wb_fifo_drain

Overview:
- Wishbone master that sequences the byte FIFO peripheral (status at BASE+0x00, pop-read at BASE+0x04, reset at BASE+0x0C).
- Polls status; when data is present, pops one byte and presents it on a valid/ready stream toward the motion/command logic.
- Also issues FIFO flushes on request and guards every bus cycle with an ack timeout.

Parameters:
- BASE_ADR, 32'h0, byte address of the FIFO peripheral register block.
- POLL_DIV, 16, idle cycles between consecutive status polls when the FIFO is empty; minimum 1.
- TIMEOUT, 64, cycles to wait for wbm_ack_i before a bus cycle is aborted; minimum 2.

Ports:
- clk  in  1  system clock, single clock domain
- reset_n  in  1  asynchronous, active-low reset
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_we_o  out  1  Wishbone write enable
- wbm_adr_o  out  32  Wishbone address
- wbm_sel_o  out  4  byte selects; always 4'hF during a cycle
- wbm_dat_o  out  32  write data; always 0
- wbm_dat_i  in  32  read data; only [7:0] used
- wbm_ack_i  in  1  Wishbone acknowledge
- enable  in  1  1 = polling allowed
- flush  in  1  single-cycle pulse; requests a FIFO reset
- m_data  out  8  popped byte
- m_valid  out  1  m_data valid
- m_ready  in  1  consumer accepts m_data
- busy  out  1  FSM not in IDLE or WAIT
- err  out  1  sticky ack-timeout flag

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. While reset_n=0, all outputs are 0, the FSM is in IDLE, the poll counter is 0, and flush_pend is 0. Reset asserted mid-bus-cycle drops cyc/stb immediately.
- All outputs are registered. cyc and stb are always equal.
- States: IDLE, RD_STAT, RD_DATA, OUT, WAIT, FLUSH.
- Flush request: a flush pulse in any state sets flush_pend.
- IDLE:
  - If flush_pend is set, go to FLUSH. Flush has priority over polling.
  - Else if enable=1, go to RD_STAT.
  - Else stay in IDLE.
- RD_STAT:
  - Drive cyc=stb=1, we=0, adr=BASE_ADR.
  - On the cycle ack=1 is sampled, drop cyc/stb on the next edge.
  - If wbm_dat_i[0] (empty) = 0, go to RD_DATA. Otherwise go to WAIT.
- RD_DATA:
  - Drive adr=BASE_ADR+4, we=0. Each RD_DATA cycle pops exactly one byte.
  - On ack, latch m_data <= wbm_dat_i[7:0] and m_valid <= 1, then go to OUT.
- OUT:
  - Hold m_data and m_valid until m_ready=1 is sampled.
  - On that edge, m_valid <= 0 and go to IDLE. Back-to-back bytes therefore cost a status read plus a data read each.
  - If flush_pend is set while in OUT, drop m_valid (the held byte is discarded) and go to FLUSH.
- WAIT:
  - Count POLL_DIV cycles, then go to IDLE.
  - A pending flush aborts the wait immediately and goes to IDLE.
  - enable=0 has no effect mid-wait.
- FLUSH:
  - Drive we=1, adr=BASE_ADR+12.
  - On ack, clear flush_pend and err, then go to IDLE.
  - A flush pulse arriving during FLUSH is absorbed: flush_pend stays 1, so one further flush follows.
- Timeout:
  - A per-cycle counter is cleared at each cycle start.
  - If TIMEOUT cycles pass with no ack, drop cyc/stb, set err=1, and go to WAIT. No data is latched.
  - In FLUSH, a timeout sets err, keeps flush_pend set, and goes to WAIT.
- Single ack rule: exactly one ack is consumed per cycle. A new cycle never starts in the same clock in which the previous ack was sampled; there is at least one idle bus clock between cycles.
- enable=0 mid-operation: the current bus cycle and any OUT handshake complete, then the FSM stays in IDLE.
- busy: 1 in RD_STAT, RD_DATA, OUT and FLUSH.

Test Plan:
- Empty FIFO, enable=1, POLL_DIV=4: the slave returns status 8'h01 each poll. Required: only reads at adr 0x00, one every ~7 cycles; m_valid never asserts.
- Slave holds bytes 8'hA5 and 8'h3C, m_ready=1. Required: sequence read 0x00, read 0x04, m_data=A5 with m_valid; then read 0x00, read 0x04, m_data=3C; then polling resumes with status 8'h01.
- Byte 8'h77 presented while m_ready=0 for 10 cycles. Required: m_valid and m_data=77 stable for all 10 cycles and no bus activity; one clock after m_ready=1, m_valid=0.
- Flush pulse while in OUT holding 8'h12. Required: m_valid drops, then a write cycle to adr 0x0C with we=1, then polling restarts with err=0.
- Slave never acks, TIMEOUT=8. Required: cyc deasserts after 8 cycles and err=1. A later flush that is acked clears err.
- reset_n pulsed low mid-RD_DATA. Required: cyc, stb and m_valid go to 0 asynchronously; after release, the first cycle is a status read.
